ledshift_cmd: RTL and testbench

// - Operator front end for the LED shifter: turns two raw push buttons into the

---
 rtl/ledshift_cmd.sv | 153 +++++++++++++++
 tb/tb_ledshift_cmd.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ledshift_cmd.sv
// ledshift_cmd: operator front end for the LED shifter.
// Synchronises, debounces and edge-detects the raw start/stop buttons.
// Issues single-cycle o_start / o_stop commands, gated by the run state.
// Optional feature macro: LEDSHIFT_CMD_AUTO_STOP_EN ends a run after AUTO_STOP_CYCLES.
module ledshift_cmd #(
    parameter int unsigned DEBOUNCE_CYCLES  = 100000,
    parameter int unsigned DB_CNT_W         = 17,
    parameter int unsigned AUTO_STOP_CYCLES = 60000,
    parameter int unsigned AS_CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_start,
    input  logic i_btn_stop,
    output logic o_start,
    output logic o_stop,
    output logic o_running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 = start button, bit 1 = stop button.
    logic [1:0]               btn_raw;
    logic [1:0]               sync1_q, sync2_q;
    logic [1:0]               stable_q, stable_d;
    logic [1:0]               stable_prev_q;
    logic [1:0][DB_CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]               press;

    state_t state_q, state_d;
    logic   start_q, start_d;
    logic   stop_q, stop_d;
    logic   auto_stop;

    assign btn_raw = {i_btn_stop, i_btn_start};

    // Two-flop synchronisers for both buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept the synced level once it has disagreed with the stable level for DEBOUNCE_CYCLES cycles.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] >= DB_LAST) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_CNT_W'(1);
            end
        end
    end

    // Debounce state and previous stable level for press detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q      <= '0;
            stable_prev_q <= '0;
            db_cnt_q      <= '0;
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            db_cnt_q      <= db_cnt_d;
        end
    end

    assign press = stable_q & ~stable_prev_q;

`ifdef LEDSHIFT_CMD_AUTO_STOP_EN
    localparam logic [AS_CNT_W-1:0] AS_LAST = AS_CNT_W'(AUTO_STOP_CYCLES - 1);

    logic [AS_CNT_W-1:0] as_cnt_q, as_cnt_d;

    // Run-length counter: held at zero outside RUN, so it starts from zero on every entry.
    always_comb begin
        as_cnt_d = '0;
        if (state_q == RUN) begin
            as_cnt_d = (as_cnt_q == AS_LAST) ? as_cnt_q : as_cnt_q + AS_CNT_W'(1);
        end
    end

    // Auto-stop counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            as_cnt_q <= '0;
        end else begin
            as_cnt_q <= as_cnt_d;
        end
    end

    assign auto_stop = (state_q == RUN) && (as_cnt_q == AS_LAST);
`else
    logic unused_as_cfg;

    assign auto_stop     = 1'b0;
    assign unused_as_cfg = ^{AS_CNT_W[0], AUTO_STOP_CYCLES[0]};
`endif

    // Command FSM: stop beats start, start only from IDLE, stop only from RUN.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        stop_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press[0] && !press[1]) begin
                    state_d = RUN;
                    start_d = 1'b1;
                end
            end
            RUN: begin
                if (press[1] || auto_stop) begin
                    state_d = IDLE;
                    stop_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            stop_q  <= stop_d;
        end
    end

    assign o_start   = start_q;
    assign o_stop    = stop_q;
    assign o_running = (state_q == RUN);

endmodule

// File: tb/tb_ledshift_cmd.sv
// Self-checking bench for ledshift_cmd (DEBOUNCE_CYCLES=4, AUTO_STOP_CYCLES=20).
// Honours LEDSHIFT_CMD_AUTO_STOP_EN for its expectations.
`timescale 1ns/1ps
module tb_ledshift_cmd;

`ifdef LEDSHIFT_CMD_AUTO_STOP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int DB     = 4;
    localparam int AUTO_N = 20;

    logic clk = 1'b0;
    logic rst, btn_start, btn_stop;
    logic o_start, o_stop, o_running;

    ledshift_cmd #(
        .DEBOUNCE_CYCLES (DB),
        .DB_CNT_W        (3),
        .AUTO_STOP_CYCLES(AUTO_N),
        .AS_CNT_W        (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_btn_start(btn_start),
        .i_btn_stop (btn_stop),
        .o_start    (o_start),
        .o_stop     (o_stop),
        .o_running  (o_running)
    );

    always #50 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int tcount   = 0;

    // Reference model: a 2-sample delay line, a run length of samples that
    // disagree with the accepted level, and a start timestamp for auto-stop.
    bit m_stable[2];
    bit m_prev[2];
    int m_run[2];
    bit dq0[$];
    bit dq1[$];
    bit m_running;
    bit e_start, e_stop;
    int m_start_edge;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, tcount);
        end
    endtask

    task automatic model_step(input bit r, input bit bs, input bit bp);
        bit raw[2];
        bit press[2];
        bit d;
        raw[0] = bs;
        raw[1] = bp;
        if (r) begin
            for (int b = 0; b < 2; b++) begin
                m_stable[b] = 1'b0;
                m_prev[b]   = 1'b0;
                m_run[b]    = 0;
            end
            dq0 = '{1'b0, 1'b0};
            dq1 = '{1'b0, 1'b0};
            m_running = 1'b0;
            e_start   = 1'b0;
            e_stop    = 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) press[b] = m_stable[b] && !m_prev[b];
            e_start = 1'b0;
            e_stop  = 1'b0;
            if (m_running) begin
                if (press[1] || (AUTO && (tcount - m_start_edge == AUTO_N))) begin
                    e_stop    = 1'b1;
                    m_running = 1'b0;
                end
            end else if (press[0] && !press[1]) begin
                e_start      = 1'b1;
                m_running    = 1'b1;
                m_start_edge = tcount;
            end
            for (int b = 0; b < 2; b++) begin
                m_prev[b] = m_stable[b];
                if (b == 0) begin
                    d = dq0.pop_front();
                    dq0.push_back(raw[0]);
                end else begin
                    d = dq1.pop_front();
                    dq1.push_back(raw[1]);
                end
                if (d != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_stable[b] = d;
                        m_run[b]    = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        tcount++;
        model_step(rst, btn_start, btn_stop);
        #1;
        chk("model_start", int'(o_start), int'(e_start));
        chk("model_stop", int'(o_stop), int'(e_stop));
        chk("model_running", int'(o_running), int'(m_running));
        chk("start_stop_exclusive", int'(o_start && o_stop), 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit bs;
        bit bp;
        int hold;
        int n_start;
        int n_stop;
        bit run_end;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int ns, np, hold_left;

        rst       = 1'b1;
        btn_start = 1'b0;
        btn_stop  = 1'b0;

        // Sequence A: reset, start from edge 10, re-press in RUN, stop from edge 50.
        do_reset(2);
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (c <= 20) chk("reset_idle_running", int'(o_running), int'(c >= 17));
            chk("seqA_start", int'(o_start), int'(c == 17 || (AUTO && c == 39)));
            chk("seqA_stop", int'(o_stop), int'(c == 57 || (AUTO && c == 37)));
            chk("seqA_running", int'(o_running),
                int'((c >= 17 && c < 57) && !(AUTO && (c == 37 || c == 38))));
            if (c == 10) btn_start = 1'b1;
            if (c == 22) btn_start = 1'b0;
            if (c == 32) btn_start = 1'b1;
            if (c == 42) btn_start = 1'b0;
            if (c == 50) btn_stop  = 1'b1;
            if (c == 60) btn_stop  = 1'b0;
        end

        // Sequence B: bouncy start (1-0-1-0 then held), final rise after edge 9.
        do_reset(2);
        ns = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (o_start) ns++;
            chk("bounce_start", int'(o_start), int'(c == 16));
            if (c == 5) btn_start = 1'b1;
            if (c == 6) btn_start = 1'b0;
            if (c == 7) btn_start = 1'b1;
            if (c == 8) btn_start = 1'b0;
            if (c == 9) btn_start = 1'b1;
        end
        chk("bounce_single_start", ns, 1);

        // Sequence C: long run (auto-stop or none), reset mid-run, button held through reset.
        for (int c = 31; c <= 265; c++) begin
            if (c == 243 || c == 244) rst = 1'b1;
            else rst = 1'b0;
            tick();
            if (c <= 216) begin
                chk("long_run_stop", int'(o_stop), int'(AUTO && c == 36));
                chk("long_run_running", int'(o_running), int'(!AUTO || c < 36));
            end
            if (c >= 243) begin
                chk("reset_midrun_stop", int'(o_stop), 0);
                chk("reset_midrun_running", int'(o_running), int'(c >= 251));
                chk("held_thru_reset_start", int'(o_start), int'(c == 251));
            end else if (c > 216) begin
                chk("repress_start", int'(o_start), int'(AUTO && c == 237));
            end
            if (c == 216) btn_start = 1'b0;
            if (c == 230) btn_start = 1'b1;
        end
        btn_start = 1'b0;

        // Table-driven steps, each level held for its step length from the step start.
        tbl[0]  = '{1'b0, 1'b0, 20, 0, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8, 1, 0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 8, 0, 0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 8, 0, 0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 8, 0, int'(AUTO), !AUTO};
        tbl[5]  = '{1'b0, 1'b1, 8, 0, int'(!AUTO), 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8, 0, 0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8, 0, 0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8, 0, 0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 8, 0, 0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8, 0, 0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8, 1, 0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 8, 0, 0, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 8, 0, 1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 8, 0, 0, 1'b0};
        do_reset(2);
        for (int s = 0; s < 15; s++) begin
            btn_start = tbl[s].bs;
            btn_stop  = tbl[s].bp;
            ns = 0;
            np = 0;
            for (int i = 0; i < tbl[s].hold; i++) begin
                tick();
                if (o_start) ns++;
                if (o_stop) np++;
            end
            chk($sformatf("tbl%0d_starts", s), ns, tbl[s].n_start);
            chk($sformatf("tbl%0d_stops", s), np, tbl[s].n_stop);
            chk($sformatf("tbl%0d_running", s), int'(o_running), int'(tbl[s].run_end));
        end

        // Randomised phase: held button levels of random length, rare resets.
        hold_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold_left == 0) begin
                btn_start = 1'($urandom_range(0, 1));
                btn_stop  = 1'($urandom_range(0, 3) == 0);
                hold_left = int'($urandom_range(1, 10));
            end
            hold_left--;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
